pipe_scroller: RTL

Produces the position of the single active pipe obstacle for the Flappy game: scrolls the pipe leftward one step per frame tick, respawns it at the right screen edge with a pseudo-random gap height, and counts pipes the bird has cleared. It is the driver of `X_Edge`/`Y_Edge` consumed by the collision checker. It reacts to that checker's `Lose` by freezing the pipe. It sits between the frame-tick generator, the collision checker and the score display.

---
 rtl/pipe_scroller.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pipe_scroller.sv
// pipe_scroller: drives the single active pipe obstacle for the Flappy game.
//
// The pipe scrolls left by cur_speed pixels on every frame Tick. When it
// leaves the left edge, it respawns at the right screen edge with a
// pseudo-random gap height taken from a free-running LFSR. The block also
// keeps a two-digit BCD count of pipes the bird has cleared, and it freezes
// the pipe when the collision checker raises Lose.
//
// Optional feature macro: PIPE_SPEEDUP_EN.
//   Defined:   cur_speed = SPEED + tens digit of Score, capped at 2*SPEED.
//   Undefined: cur_speed = SPEED.
//
// Ports:
//   Clk          system clock
//   reset        asynchronous, active-high reset
//   Start        begin a game (level, sampled in QIdle)
//   Ack          acknowledge game over (level, sampled in QHalt)
//   Lose         collision flag from the collision checker
//   Tick         one-cycle frame pulse
//   Bird_X       bird x coordinate
//   X_Edge       left edge of the current pipe
//   Y_Edge       top edge of the gap
//   Score        two BCD digits {tens, ones}
//   Pipe_Passed  one-cycle pulse when the score increments
//   Q_Idle/Q_Run/Q_Halt  one-hot state flags
module pipe_scroller #(
    parameter int unsigned SPEED     = 2,
    parameter int unsigned PIPE_W    = 80,
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned Y_MIN     = 60,
    parameter logic [9:0]  LFSR_SEED = 10'h2A5
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       Start,
    input  logic       Ack,
    input  logic       Lose,
    input  logic       Tick,
    input  logic [9:0] Bird_X,
    output logic [9:0] X_Edge,
    output logic [9:0] Y_Edge,
    output logic [7:0] Score,
    output logic       Pipe_Passed,
    output logic       Q_Idle,
    output logic       Q_Run,
    output logic       Q_Halt
);

    localparam logic [9:0]  SPAWN_X  = 10'(SCREEN_W);
    localparam logic [9:0]  RESET_Y  = 10'(Y_MIN + 128);
    localparam logic [9:0]  Y_BASE   = 10'(Y_MIN);
    localparam logic [10:0] PIPE_W11 = 11'(PIPE_W);

    typedef enum logic [2:0] {
        QIdle = 3'b001,
        QRun  = 3'b010,
        QHalt = 3'b100
    } state_t;

    state_t     state;
    logic [9:0] lfsr;
    logic       passed;

    logic [4:0] cur_speed;
    logic [9:0] new_y;
    logic       do_respawn;
    logic       do_score;
    logic [7:0] score_inc;

    // Free-running in every state so the game seed depends on Start timing.
    // x^10 + x^7 + 1 is maximal-length, so a nonzero seed never reaches zero.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
        end
    end

`ifdef PIPE_SPEEDUP_EN
    localparam logic [4:0] SPEED_MAX = 5'(2 * SPEED);
    logic [4:0] speed_sum;

    always_comb begin
        speed_sum = 5'(SPEED) + {1'b0, Score[7:4]};
        cur_speed = (speed_sum > SPEED_MAX) ? SPEED_MAX : speed_sum;
    end
`else
    assign cur_speed = 5'(SPEED);
`endif

    always_comb begin
        new_y      = Y_BASE + {2'b00, lfsr[7:0]};
        do_respawn = Tick && (X_Edge < {5'b00000, cur_speed});
        // 11-bit sum so a pipe near the right edge cannot wrap past the bird.
        do_score   = !passed && !do_respawn &&
                     (({1'b0, X_Edge} + PIPE_W11) < {1'b0, Bird_X});
    end

    // BCD increment, saturating at 99.
    always_comb begin
        score_inc = Score;
        if (Score != 8'h99) begin
            if (Score[3:0] >= 4'd9) begin
                score_inc = {Score[7:4] + 4'd1, 4'd0};
            end else begin
                score_inc = {Score[7:4], Score[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state       <= QIdle;
            X_Edge      <= SPAWN_X;
            Y_Edge      <= RESET_Y;
            Score       <= 8'h00;
            Pipe_Passed <= 1'b0;
            passed      <= 1'b0;
        end else begin
            Pipe_Passed <= 1'b0;
            case (state)
                QIdle: begin
                    if (Start) begin
                        state  <= QRun;
                        X_Edge <= SPAWN_X;
                        Y_Edge <= new_y;
                        Score  <= 8'h00;
                        passed <= 1'b0;
                    end
                end
                QRun: begin
                    // Lose wins over Tick: the pipe freezes where it was hit.
                    if (Lose) begin
                        state <= QHalt;
                    end else begin
                        if (do_respawn) begin
                            X_Edge <= SPAWN_X;
                            Y_Edge <= new_y;
                            passed <= 1'b0;
                        end else if (Tick) begin
                            X_Edge <= X_Edge - {5'b00000, cur_speed};
                        end
                        if (do_score) begin
                            passed      <= 1'b1;
                            Score       <= score_inc;
                            Pipe_Passed <= 1'b1;
                        end
                    end
                end
                QHalt: begin
                    // Score stays visible until the next Start.
                    if (Ack) begin
                        state  <= QIdle;
                        X_Edge <= SPAWN_X;
                        Y_Edge <= RESET_Y;
                    end
                end
                default: begin
                    state <= QIdle;
                end
            endcase
        end
    end

    assign Q_Idle = (state == QIdle);
    assign Q_Run  = (state == QRun);
    assign Q_Halt = (state == QHalt);

endmodule
